// File: rtl/mem_access_ctrl.sv
// Pipelined MEM-stage data-SRAM controller: keeps up to OUTSTANDING accesses in flight
// in order, formats store lanes, extracts loads and buffers results against WB stalls.
module mem_access_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_wr,
  input  logic [1:0]                    in_size,
  input  logic                          in_signed,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [31:0]                   in_wdata,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_wr,
  output logic [31:0]                   out_rdata,
  output logic                          data_sram_req,
  output logic                          data_sram_wr,
  output logic [1:0]                    data_sram_size,
  output logic [3:0]                    data_sram_wstrb,
  output logic [ADDR_W-1:0]             data_sram_addr,
  output logic [31:0]                   data_sram_wdata,
  input  logic                          data_sram_addr_ok,
  input  logic                          data_sram_data_ok,
  input  logic [31:0]                   data_sram_rdata,
  output logic [$clog2(OUTSTANDING):0]  inflight_cnt,
  output logic                          proto_err
);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int CW = PW + 1;

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{wd[7:0]}};
      2'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Tracker tag layout: {wr, size[1:0], signed, addr[1:0]}
  logic [5:0]             trk_tag [OUTSTANDING];
  logic [OUTSTANDING-1:0] trk_kill;
  logic [PW:0]            trk_wp, trk_rp;
  logic [32:0]            res_mem [OUTSTANDING];
  logic [PW:0]            res_wp, res_rp;

  logic        accept, trk_empty, pop, head_kill, drop, res_push, consume;
  logic [5:0]  head_tag;
  logic [CW-1:0] res_cnt, ret_cnt, cnt_next;
  logic [31:0] res_word;

  assign data_sram_req   = in_valid & ~flush & (inflight_cnt < CW'(OUTSTANDING));
  assign in_ready        = data_sram_req & data_sram_addr_ok;
  assign data_sram_wr    = in_wr;
  assign data_sram_size  = in_size;
  assign data_sram_addr  = in_addr;
  assign data_sram_wstrb = in_wr ? lane_strb(in_size, in_addr[1:0]) : 4'b0000;
  assign data_sram_wdata = lane_wdata(in_size, in_wdata);

  assign accept    = in_ready;
  assign trk_empty = (trk_wp == trk_rp);
  assign pop       = data_sram_data_ok & ~trk_empty;
  assign head_tag  = trk_tag[trk_rp[PW-1:0]];
  // A flush in the same cycle as a response kills the entry being popped too.
  assign head_kill = trk_kill[trk_rp[PW-1:0]] | flush;
  assign drop      = pop & head_kill;
  assign res_push  = pop & ~head_kill;
  assign res_word  = head_tag[5] ? 32'h0000_0000
                   : load_extract(data_sram_rdata, head_tag[4:3], head_tag[2], head_tag[1:0]);

  assign out_valid = (res_wp != res_rp);
  assign out_wr    = out_valid & res_mem[res_rp[PW-1:0]][32];
  assign out_rdata = out_valid ? res_mem[res_rp[PW-1:0]][31:0] : 32'h0000_0000;
  assign consume   = out_valid & out_ready;

  assign res_cnt  = res_wp - res_rp;
  assign ret_cnt  = flush ? res_cnt : {{PW{1'b0}}, consume};
  assign cnt_next = inflight_cnt + {{PW{1'b0}}, accept} - {{PW{1'b0}}, drop} - ret_cnt;

  always_ff @(posedge clk) begin
    if (accept) trk_tag[trk_wp[PW-1:0]] <= {in_wr, in_size, in_signed, in_addr[1:0]};
    if (res_push) res_mem[res_wp[PW-1:0]] <= {head_tag[5], res_word};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_wp       <= '0;
      trk_rp       <= '0;
      trk_kill     <= '0;
      res_wp       <= '0;
      res_rp       <= '0;
      inflight_cnt <= '0;
      proto_err    <= 1'b0;
    end else begin
      inflight_cnt <= cnt_next;
      if (accept) trk_wp <= trk_wp + 1'b1;
      if (pop)    trk_rp <= trk_rp + 1'b1;
      if (flush)       trk_kill <= '1;
      else if (accept) trk_kill[trk_wp[PW-1:0]] <= 1'b0;
      if (flush) begin
        res_rp <= res_wp;
      end else begin
        if (res_push) res_wp <= res_wp + 1'b1;
        if (consume)  res_rp <= res_rp + 1'b1;
      end
      if (data_sram_data_ok & trk_empty) proto_err <= 1'b1;
    end
  end
endmodule
